// File: rtl/cpu_stim_pkg.sv
// -----------------------------------------------------------------------------
// cpu_stim_pkg
// Shared definitions for the CPU run/stimulus controller:
//   - state_e     : run-controller FSM states (RESET, RUN, DONE)
//   - DEF_INT_W   : default number of external interrupt channels
//   - DEF_CNT_W   : default width of the run-cycle counter / scheduled cycle
//   - DEF_LEN_W   : default width of the pulse-length field
// -----------------------------------------------------------------------------
package cpu_stim_pkg;

  localparam int DEF_INT_W = 6;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_LEN_W = 8;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : cpu_stim_pkg

// File: rtl/cpu_stim_ctrl_int_slot.sv
// -----------------------------------------------------------------------------
// stim_int_slot
// Single-entry external-interrupt injection slot: holds one scheduled request,
// compares it against the run-cycle counter and drives the interrupt pulse.
//
// Optional feature macro: STIM_LEVEL_INT_EN
//   undefined : fixed-length pulses of max(len,1) cycles
//   defined   : after the timed part of the pulse, each fired channel holds
//               until its int_ack bit is seen; the slot frees once all clear
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   run        in   controller is in RUN (firing allowed)
//   halt       in   controller is in DONE (slot discarded, outputs forced 0)
//   open       in   controller accepts requests (out of reset, not DONE)
//   cycle_cnt  in   current run-cycle index
//   inj_valid  in   injection request valid
//   inj_ready  out  slot free and controller open
//   inj_cycle  in   run-cycle index at which the pulse starts
//   inj_mask   in   channels to assert
//   inj_len    in   pulse length in cycles (0 treated as 1)
//   int_ack    in   per-channel acknowledge (STIM_LEVEL_INT_EN only)
//   ext_int    out  interrupt lines to the CPU
// -----------------------------------------------------------------------------
module stim_int_slot
  import cpu_stim_pkg::*;
#(
  parameter int INT_W = DEF_INT_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             halt,
  input  logic             open,
  input  logic [CNT_W-1:0] cycle_cnt,
  input  logic             inj_valid,
  output logic             inj_ready,
  input  logic [CNT_W-1:0] inj_cycle,
  input  logic [INT_W-1:0] inj_mask,
  input  logic [LEN_W-1:0] inj_len,
`ifdef STIM_LEVEL_INT_EN
  input  logic [INT_W-1:0] int_ack,
`endif
  output logic [INT_W-1:0] ext_int
);

  logic             full_q;    // slot holds a request (pending or firing)
  logic             active_q;  // pulse currently driven
  logic [INT_W-1:0] mask_q;
  logic [CNT_W-1:0] cycle_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] remain_q;  // timed pulse cycles left, 1 = final cycle
  logic [INT_W-1:0] ext_q;

  logic accept;
  logic fire;
  logic last;

  assign inj_ready = open & ~full_q;
  assign accept    = inj_valid & inj_ready;
  // Unsigned compare: a request whose cycle has already passed fires at once.
  assign fire      = run & full_q & ~active_q & (cycle_cnt >= cycle_q);
  assign last      = (remain_q == LEN_W'(1));

  // The edge that enters DONE still sees RUN, so gate the lines by state as
  // well; the registers themselves are cleared on the following edge.
  assign ext_int   = halt ? '0 : ext_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the payload registers are reset too; it is a single entry, and
      // it keeps the slot contents deterministic for anyone probing them.
      full_q   <= 1'b0;
      active_q <= 1'b0;
      mask_q   <= '0;
      cycle_q  <= '0;
      len_q    <= '0;
      remain_q <= '0;
      ext_q    <= '0;
    end else if (halt) begin
      full_q   <= 1'b0;
      active_q <= 1'b0;
      ext_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this
      // block reading pre-edge values, so accept/fire/clear cannot race.
      if (accept) begin
        full_q  <= 1'b1;
        mask_q  <= inj_mask;
        cycle_q <= inj_cycle;
        len_q   <= inj_len;
      end

      if (fire) begin
        ext_q    <= mask_q;
        active_q <= 1'b1;
        remain_q <= (len_q == '0) ? LEN_W'(1) : len_q;
      end else if (active_q) begin
`ifdef STIM_LEVEL_INT_EN
        if (!last) begin
          remain_q <= remain_q - LEN_W'(1);
        end else begin
          // Timed part over: each channel now waits for its own acknowledge.
          ext_q <= ext_q & ~int_ack;
          if ((ext_q & ~int_ack) == '0) begin
            active_q <= 1'b0;
            full_q   <= 1'b0;
          end
        end
`else
        if (last) begin
          ext_q    <= '0;
          active_q <= 1'b0;
          full_q   <= 1'b0;
        end else begin
          remain_q <= remain_q - LEN_W'(1);
        end
`endif
      end
    end
  end

endmodule : stim_int_slot

// File: rtl/cpu_stim_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_stim_ctrl
// Run controller for the pipelined CPU harness: sequences CPU reset, counts
// run cycles up to a limit and flags done, and injects scheduled external
// interrupt pulses through a valid/ready request port (see stim_int_slot).
//
// Optional feature macro: STIM_LEVEL_INT_EN (adds int_ack, level interrupts)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   inj_valid  in   injection request valid
//   inj_ready  out  slot free, request accepted when valid & ready
//   inj_cycle  in   run-cycle index at which the pulse starts
//   inj_mask   in   channels to assert
//   inj_len    in   pulse length in cycles (0 treated as 1)
//   cpu_rst    out  active-high reset to the CPU
//   ext_int    out  interrupt lines to the CPU
//   cycle_cnt  out  current run-cycle index
//   done       out  run finished, sticky until reset
//   int_ack    in   per-channel acknowledge (STIM_LEVEL_INT_EN only)
// -----------------------------------------------------------------------------
module cpu_stim_ctrl
  import cpu_stim_pkg::*;
#(
  parameter int INT_W      = DEF_INT_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int RST_CYCLES = 1,
  parameter int RUN_CYCLES = 100,
  parameter int LEN_W      = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inj_valid,
  output logic             inj_ready,
  input  logic [CNT_W-1:0] inj_cycle,
  input  logic [INT_W-1:0] inj_mask,
  input  logic [LEN_W-1:0] inj_len,
  output logic             cpu_rst,
  output logic [INT_W-1:0] ext_int,
  output logic [CNT_W-1:0] cycle_cnt,
`ifdef STIM_LEVEL_INT_EN
  input  logic [INT_W-1:0] int_ack,
`endif
  output logic             done
);

  // Reset-phase counter only needs to reach RST_CYCLES-1 (0 or 1 both mean 1).
  localparam int              RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RST_LAST = (RST_CYCLES > 1) ? RC_W'(RST_CYCLES - 1) : '0;
  // Compared in 64 bits so a RUN_CYCLES beyond the counter range never
  // matches; the counter then saturates and the run never ends.
  localparam logic [63:0]     RUN_LAST = 64'(RUN_CYCLES) - 64'd1;

  state_e           state_q;
  state_e           state_d;
  logic [RC_W-1:0]  rst_cnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_last;
  logic             cnt_max;
  logic             in_run;
  logic             in_done;
  logic             open;

  assign run_last = (64'(cnt_q) == RUN_LAST);
  assign cnt_max  = &cnt_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cpu_rst = 1'b0;
    done    = 1'b0;
    in_run  = 1'b0;
    in_done = 1'b0;
    unique case (state_q)
      ST_RESET: begin
        cpu_rst = 1'b1;
        if (rst_cnt_q == RST_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        in_run = 1'b1;
        if (run_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        in_done = 1'b1;
      end
      default: begin
        cpu_rst = 1'b1;
        state_d = ST_RESET;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RESET;
      rst_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_RESET && rst_cnt_q != RST_LAST) begin
        rst_cnt_q <= rst_cnt_q + RC_W'(1);
      end
      // Counter holds on the edge into DONE so it freezes at RUN_CYCLES-1.
      if (state_q == ST_RUN && state_d == ST_RUN && !cnt_max) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt = cnt_q;
  // rst is used directly so inj_ready reads 0 while the controller is held.
  assign open      = rst & ~in_done;

  stim_int_slot #(
    .INT_W (INT_W),
    .CNT_W (CNT_W),
    .LEN_W (LEN_W)
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .run       (in_run),
    .halt      (in_done),
    .open      (open),
    .cycle_cnt (cnt_q),
    .inj_valid (inj_valid),
    .inj_ready (inj_ready),
    .inj_cycle (inj_cycle),
    .inj_mask  (inj_mask),
    .inj_len   (inj_len),
`ifdef STIM_LEVEL_INT_EN
    .int_ack   (int_ack),
`endif
    .ext_int   (ext_int)
  );

endmodule : cpu_stim_ctrl

// File: tb/tb_cpu_stim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_stim_ctrl
// Self-checking bench for cpu_stim_ctrl (default build, fixed-length pulses).
// The reference model works in terms of "edges since reset release": the run
// phase and cycle index follow from that count, and each accepted request
// becomes a window of run-cycle indices [start+1, start+len] in which its mask
// is expected on ext_int.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cpu_stim_ctrl;

  localparam int INT_W      = 6;
  localparam int CNT_W      = 16;
  localparam int LEN_W      = 8;
  localparam int RST_CYCLES = 1;
  localparam int RUN_CYCLES = 100;

  localparam int PH_RESET = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_DONE  = 2;

  logic             clk       = 1'b0;
  logic             rst       = 1'b0;
  logic             inj_valid = 1'b0;
  logic             inj_ready;
  logic [CNT_W-1:0] inj_cycle = '0;
  logic [INT_W-1:0] inj_mask  = '0;
  logic [LEN_W-1:0] inj_len   = '0;
  logic             cpu_rst;
  logic [INT_W-1:0] ext_int;
  logic [CNT_W-1:0] cycle_cnt;
  logic             done;
`ifdef STIM_LEVEL_INT_EN
  logic [INT_W-1:0] int_ack   = '0;
`endif

  always #5 clk = ~clk;

  cpu_stim_ctrl #(
    .INT_W      (INT_W),
    .CNT_W      (CNT_W),
    .RST_CYCLES (RST_CYCLES),
    .RUN_CYCLES (RUN_CYCLES),
    .LEN_W      (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inj_valid (inj_valid),
    .inj_ready (inj_ready),
    .inj_cycle (inj_cycle),
    .inj_mask  (inj_mask),
    .inj_len   (inj_len),
    .cpu_rst   (cpu_rst),
    .ext_int   (ext_int),
    .cycle_cnt (cycle_cnt),
`ifdef STIM_LEVEL_INT_EN
    .int_ack   (int_ack),
`endif
    .done      (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int               k;          // rising edges since reset release
  bit               ent_v;      // model slot occupied
  int               ent_f;      // run index at which the request fires
  int               ent_l;      // effective pulse length
  logic [INT_W-1:0] ent_m;
  logic [INT_W-1:0] exp_ext;
  bit               exp_ready;

  // request currently presented by the bench
  bit               req_v;
  int               req_cycle;
  int               req_len;
  logic [INT_W-1:0] req_mask;

  function automatic int phase_of(input int kk);
    if (kk < RST_CYCLES) return PH_RESET;
    if (kk - RST_CYCLES < RUN_CYCLES) return PH_RUN;
    return PH_DONE;
  endfunction

  function automatic int cnt_of(input int kk);
    if (kk < RST_CYCLES) return 0;
    if (kk - RST_CYCLES < RUN_CYCLES) return kk - RST_CYCLES;
    return RUN_CYCLES - 1;
  endfunction

  task automatic sample_check();
    int ph;
    int c;
    ph = phase_of(k);
    c  = cnt_of(k);
    if (ent_v && (ph == PH_DONE || (ph == PH_RUN && c > ent_f + ent_l))) ent_v = 1'b0;
    exp_ext   = (ent_v && ph == PH_RUN && c >= ent_f + 1 && c <= ent_f + ent_l) ? ent_m : '0;
    exp_ready = (ph != PH_DONE) && !ent_v;
    check("cpu_rst",   cpu_rst,   ph == PH_RESET);
    check("done",      done,      ph == PH_DONE);
    check("cycle_cnt", cycle_cnt, c);
    check("ext_int",   ext_int,   exp_ext);
    check("inj_ready", inj_ready, exp_ready);
  endtask

  task automatic drive(output bit acc);
    inj_valid = req_v;
    inj_cycle = req_v ? CNT_W'(req_cycle) : CNT_W'($urandom);
    inj_mask  = req_v ? req_mask : INT_W'($urandom);
    inj_len   = req_v ? LEN_W'(req_len) : LEN_W'($urandom);
    acc       = req_v && exp_ready;
  endtask

  task automatic advance(input bit acc);
    int c;
    @(posedge clk);
    k++;
    if (acc) begin
      c     = cnt_of(k);
      ent_v = 1'b1;
      ent_f = (req_cycle > c) ? req_cycle : c;
      ent_l = (req_len == 0) ? 1 : req_len;
      ent_m = req_mask;
      req_v = 1'b0;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic rand_policy();
    int r;
    int c;
    if (!req_v && $urandom_range(0, 1) == 0) begin
      r = int'($urandom_range(0, 8));
      c = cnt_of(k) + r - 3;
      if (c < 0) c = 0;
      if ($urandom_range(0, 11) == 0) c = 200 + r;  // never reached in this run
      req_v     = 1'b1;
      req_cycle = c;
      req_mask  = INT_W'($urandom);
      req_len   = int'($urandom_range(0, 4));
    end
  endtask

  // Assert reset (immediate-effect checks), hold across an edge, release at a
  // falling edge and restart the model.
  task automatic do_reset(input string tag);
    rst       = 1'b0;
    inj_valid = 1'b1;
    #1;
    check({tag, "_ext_now"},   ext_int,   '0);
    check({tag, "_cpurst_now"}, cpu_rst,  1'b1);
    check({tag, "_ready_now"}, inj_ready, 1'b0);
    check({tag, "_cnt_now"},   cycle_cnt, '0);
    check({tag, "_done_now"},  done,      1'b0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_cpurst_held"}, cpu_rst,  1'b1);
    check({tag, "_ready_held"}, inj_ready, 1'b0);
    rst       = 1'b1;
    inj_valid = 1'b0;
    k     = 0;
    ent_v = 1'b0;
    req_v = 1'b0;
    #1;
  endtask

  // Directed requests for the first run: {earliest k, cycle, mask, len}.
  int               dir_k    [3] = '{0, 23, 31};
  int               dir_cyc  [3] = '{20, 5, 5};
  logic [INT_W-1:0] dir_mask [3] = '{6'b000100, 6'b100000, 6'b010001};
  int               dir_len  [3] = '{3, 0, 0};

  initial begin
    bit acc;
    int di;
    bit mid_seen;

    // ---- run 1: directed schedule, full run to DONE ----
    do_reset("por");
    di = 0;
    for (int i = 0; i < RST_CYCLES + RUN_CYCLES + 4; i++) begin
      sample_check();
      if (k == 0)  check("first_ready", inj_ready, 1'b1);
      if (k == 1)  check("cpu_rst_fall", cpu_rst, 1'b0);
      if (k == 22) check("pulse_on_21", ext_int, 6'b000100);
      if (k == 24) check("pulse_on_23", ext_int, 6'b000100);
      if (k == 23) check("busy_ready", inj_ready, 1'b0);
      if (k == 25) check("ready_after_pulse", inj_ready, 1'b1);
      if (k == 27) check("queued_pulse_26", ext_int, 6'b100000);
      if (k == 33) check("late_pulse_32", ext_int, 6'b010001);
      if (k == 34) check("late_pulse_end", ext_int, 6'b000000);
      if (!req_v && di < 3 && k >= dir_k[di]) begin
        req_v     = 1'b1;
        req_cycle = dir_cyc[di];
        req_mask  = dir_mask[di];
        req_len   = dir_len[di];
        di++;
      end
      drive(acc);
      advance(acc);
    end
    check("done_sticky", done, 1'b1);
    check("cnt_frozen", cycle_cnt, RUN_CYCLES - 1);
    check("done_ext_zero", ext_int, '0);
    check("done_ready_zero", inj_ready, 1'b0);

    // ---- run 2: random stimulus, reset pulled mid-pulse ----
    do_reset("rerun");
    mid_seen = 1'b0;
    for (int i = 0; i < RST_CYCLES + RUN_CYCLES; i++) begin
      sample_check();
      if (k > 30 && exp_ext != '0) begin
        mid_seen = 1'b1;
        break;
      end
      rand_policy();
      drive(acc);
      advance(acc);
    end
    check("mid_pulse_found", mid_seen, 1'b1);
    do_reset("midpulse");

    // ---- run 3: random stimulus through a complete run ----
    for (int i = 0; i < RST_CYCLES + RUN_CYCLES + 6; i++) begin
      sample_check();
      rand_policy();
      drive(acc);
      advance(acc);
    end
    check("done_final", done, 1'b1);
    check("cnt_final", cycle_cnt, RUN_CYCLES - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule : tb_cpu_stim_ctrl
